// File: rtl/tick_source_select_if.sv
`default_nettype none
// ============================================================================
// tick_source_select_if : tick-source selection bus (sources, select, mode,
//                         prescale in; tick pulse and switch-busy out).
// Revision: 1.0
// ============================================================================
interface tick_source_select_if #(
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = 2,
   parameter int DIV_W   = 8
);
   logic [NUM_SRC-1:0] clk_in;
   logic [SEL_W-1:0]   clk_sel;
   logic [1:0]         edge_mode;
   logic [DIV_W-1:0]   div;
   logic               clk_ena;
   logic               sel_busy;

   modport master (
      output clk_in, clk_sel, edge_mode, div,
      input  clk_ena, sel_busy
   );

   modport slave (
      input  clk_in, clk_sel, edge_mode, div,
      output clk_ena, sel_busy
   );
endinterface
`default_nettype wire

// File: rtl/tick_source_select.sv
`default_nettype none
// ============================================================================
// tick_source_select : synchronises asynchronous tick sources, selects one,
//                      detects edges and prescales them into clk_ena pulses.
// Revision: 1.0
// ============================================================================
module tick_source_select #(
   parameter int NUM_SRC     = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DIV_W       = 8,
   parameter int SEL_W       = 2
) (
   input  wire logic           clk,
   input  wire logic           rst,
   tick_source_select_if.slave bus
);
   localparam int               BLK_W        = $clog2(SYNC_STAGES + 2);
   localparam logic [BLK_W-1:0] C_BLANK_LOAD = BLK_W'(SYNC_STAGES + 1);

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      SWITCH = 1'b1
   } state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_sync [NUM_SRC];
   logic [SEL_W-1:0]       r_sel;
   logic [1:0]             r_mode;
   logic                   r_prev;
   logic [DIV_W-1:0]       r_count;
   logic [BLK_W-1:0]       r_blank;
   logic                   r_ena;
   logic                   r_busy;

   logic [NUM_SRC-1:0]     w_sync_q;
   logic                   w_cur;
   logic                   w_qual;
   logic                   w_change;

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (rst) begin
            r_sync[i] <= '0;
         end else begin
            r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], bus.clk_in[i]};
         end
      end
   end

   // An out-of-range select matches no source, so the mux yields a clean 0.
   always_comb begin
      w_cur = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_sync_q[i] = r_sync[i][SYNC_STAGES-1];
         if (r_sel == SEL_W'(i)) begin
            w_cur = w_sync_q[i];
         end
      end
   end

   always_comb begin
      case (r_mode)
         2'b00:   w_qual = w_cur & ~r_prev;
         2'b01:   w_qual = ~w_cur & r_prev;
         2'b10:   w_qual = w_cur ^ r_prev;
         default: w_qual = 1'b0;
      endcase
   end

   assign w_change = (bus.clk_sel != r_sel) || (bus.edge_mode != r_mode);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RUN;
         r_sel   <= '0;
         r_mode  <= '0;
         r_prev  <= 1'b0;
         r_count <= '0;
         r_blank <= '0;
         r_ena   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_prev <= w_cur;
         r_ena  <= 1'b0;
         // A change in either state restarts blanking so stale sync data never ticks.
         if (w_change) begin
            r_sel   <= bus.clk_sel;
            r_mode  <= bus.edge_mode;
            r_blank <= C_BLANK_LOAD;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= SWITCH;
         end else begin
            case (r_state)
               SWITCH: begin
                  r_count <= '0;
                  r_blank <= r_blank - BLK_W'(1);
                  if (r_blank == BLK_W'(1)) begin
                     r_busy  <= 1'b0;
                     r_state <= RUN;
                  end
               end
               default: begin
                  if (w_qual) begin
                     if (r_count >= bus.div) begin
                        r_ena   <= 1'b1;
                        r_count <= '0;
                     end else begin
                        r_count <= r_count + DIV_W'(1);
                     end
                  end
               end
            endcase
         end
      end
   end

   assign bus.clk_ena  = r_ena;
   assign bus.sel_busy = r_busy;
endmodule
`default_nettype wire
